cvxif_offload_ctrl: RTL and testbench

CVXIF_OFFLOAD_CTRL -- requirements
Module: cvxif_offload_ctrl

---
 rtl/cvxif_offload_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_cvxif_offload_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_offload_ctrl.sv
// CV-X-IF offload controller: hands one core instruction at a time to a coprocessor,
// waits for the matching result and returns it as a single register-file writeback.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a new core instruction
// ISSUE    | presenting the captured instruction/operands to the coprocessor
// WAIT_RES | accepted with writeback, waiting for the result carrying our ID
// RESP     | one-cycle writeback (if requested) and done pulse
module cvxif_offload_ctrl #(
   parameter int XLEN          = 32,
   parameter int IdW           = 3,
   parameter int TimeoutCycles = 64
) (
   input  logic                clk_i,
   input  logic                rst_ni,

   input  logic                instr_valid_i,
   output logic                instr_ready_o,
   input  logic [31:0]         instr_i,
   input  logic [XLEN-1:0]     rs1_i,
   input  logic [XLEN-1:0]     rs2_i,
   input  logic [XLEN-1:0]     rs3_i,

   output logic                x_issue_valid_o,
   input  logic                x_issue_ready_i,
   output logic [31:0]         x_issue_instr_o,
   output logic [IdW-1:0]      x_issue_id_o,
   output logic [3*XLEN-1:0]   x_issue_rs_o,
   output logic [2:0]          x_issue_rs_valid_o,
   input  logic                x_issue_resp_accept_i,
   input  logic                x_issue_resp_writeback_i,
   input  logic [2:0]          x_issue_resp_register_read_i,

   input  logic                x_result_valid_i,
   output logic                x_result_ready_o,
   input  logic [IdW-1:0]      x_result_id_i,
   input  logic [XLEN-1:0]     x_result_data_i,
   input  logic [4:0]          x_result_rd_i,
   input  logic                x_result_we_i,

   output logic                wb_valid_o,
   output logic [4:0]          wb_rd_o,
   output logic [XLEN-1:0]     wb_data_o,

   output logic                illegal_o,
   output logic                timeout_o,
   output logic                done_o,
   output logic                busy_o
);

   localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RES = 2'd2,
      RESP     = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       instr_q, instr_d;
   logic [XLEN-1:0]   rs1_q, rs1_d;
   logic [XLEN-1:0]   rs2_q, rs2_d;
   logic [XLEN-1:0]   rs3_q, rs3_d;
   logic [IdW-1:0]    id_q, id_d;
   logic [IdW-1:0]    out_id_q, out_id_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              resp_accept_q, resp_accept_d;
   logic              resp_wb_q, resp_wb_d;
   logic [2:0]        resp_rr_q, resp_rr_d;
   logic [XLEN-1:0]   res_data_q, res_data_d;
   logic [4:0]        res_rd_q, res_rd_d;
   logic              res_we_q, res_we_d;
   logic              illegal_q, illegal_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;

   logic              res_match;
   logic              unused_resp_rr;

   // register_read is kept for visibility only; every operand is always sent valid
   assign unused_resp_rr = ^resp_rr_q;

   assign res_match = x_result_valid_i && (x_result_id_i == out_id_q)
                      && resp_accept_q && resp_wb_q;

   always_comb begin
      state_d       = state_q;
      instr_d       = instr_q;
      rs1_d         = rs1_q;
      rs2_d         = rs2_q;
      rs3_d         = rs3_q;
      id_d          = id_q;
      out_id_d      = out_id_q;
      cnt_d         = cnt_q;
      resp_accept_d = resp_accept_q;
      resp_wb_d     = resp_wb_q;
      resp_rr_d     = resp_rr_q;
      res_data_d    = res_data_q;
      res_rd_d      = res_rd_q;
      res_we_d      = res_we_q;
      illegal_d     = 1'b0;
      done_d        = 1'b0;
      timeout_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (instr_valid_i) begin
               instr_d = instr_i;
               rs1_d   = rs1_i;
               rs2_d   = rs2_i;
               rs3_d   = rs3_i;
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            if (x_issue_ready_i) begin
               if (!x_issue_resp_accept_i) begin
                  illegal_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  id_d = id_q + IdW'(1);
                  if (!x_issue_resp_writeback_i) begin
                     done_d  = 1'b1;
                     state_d = IDLE;
                  end else begin
                     out_id_d      = id_q;
                     resp_accept_d = x_issue_resp_accept_i;
                     resp_wb_d     = x_issue_resp_writeback_i;
                     resp_rr_d     = x_issue_resp_register_read_i;
                     cnt_d         = '0;
                     state_d       = WAIT_RES;
                  end
               end
            end
         end

         WAIT_RES: begin
            // a matched result wins over a timeout expiring in the same cycle
            if (res_match) begin
               res_data_d = x_result_data_i;
               res_rd_d   = x_result_rd_i;
               res_we_d   = x_result_we_i;
               state_d    = RESP;
            end else if (cnt_q == CntLast) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         instr_q       <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rs3_q         <= '0;
         id_q          <= '0;
         out_id_q      <= '0;
         cnt_q         <= '0;
         resp_accept_q <= 1'b0;
         resp_wb_q     <= 1'b0;
         resp_rr_q     <= '0;
         res_data_q    <= '0;
         res_rd_q      <= '0;
         res_we_q      <= 1'b0;
         illegal_q     <= 1'b0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         instr_q       <= instr_d;
         rs1_q         <= rs1_d;
         rs2_q         <= rs2_d;
         rs3_q         <= rs3_d;
         id_q          <= id_d;
         out_id_q      <= out_id_d;
         cnt_q         <= cnt_d;
         resp_accept_q <= resp_accept_d;
         resp_wb_q     <= resp_wb_d;
         resp_rr_q     <= resp_rr_d;
         res_data_q    <= res_data_d;
         res_rd_q      <= res_rd_d;
         res_we_q      <= res_we_d;
         illegal_q     <= illegal_d;
         done_q        <= done_d;
         timeout_q     <= timeout_d;
      end
   end

   assign instr_ready_o      = (state_q == IDLE);
   assign busy_o             = (state_q != IDLE);

   assign x_issue_valid_o    = (state_q == ISSUE);
   assign x_issue_instr_o    = x_issue_valid_o ? instr_q : '0;
   assign x_issue_id_o       = x_issue_valid_o ? id_q : '0;
   assign x_issue_rs_o       = x_issue_valid_o ? {rs3_q, rs2_q, rs1_q} : '0;
   assign x_issue_rs_valid_o = x_issue_valid_o ? 3'b111 : 3'b000;

   assign x_result_ready_o   = (state_q == WAIT_RES);

   // writes to x0 are suppressed
   assign wb_valid_o         = (state_q == RESP) && res_we_q && (res_rd_q != 5'd0);
   assign wb_rd_o            = wb_valid_o ? res_rd_q : '0;
   assign wb_data_o          = wb_valid_o ? res_data_q : '0;

   assign illegal_o          = illegal_q;
   assign timeout_o          = timeout_q;
   assign done_o             = done_q || (state_q == RESP);

endmodule

// File: tb/tb_cvxif_offload_ctrl.sv
// Directed bench for cvxif_offload_ctrl: stimulus pushes expected events into a
// scoreboard queue, an independent monitor pops and compares as the DUT emits them.
module tb_cvxif_offload_ctrl;

   localparam int XLEN = 32;
   localparam int IdW  = 3;

   localparam logic [2:0] K_ISS  = 3'd1;
   localparam logic [2:0] K_WB   = 3'd2;
   localparam logic [2:0] K_DONE = 3'd3;
   localparam logic [2:0] K_ILL  = 3'd4;
   localparam logic [2:0] K_TMO  = 3'd5;

   logic                clk_i;
   logic                rst_ni;
   logic                instr_valid_i;
   logic                instr_ready_o;
   logic [31:0]         instr_i;
   logic [XLEN-1:0]     rs1_i, rs2_i, rs3_i;
   logic                x_issue_valid_o;
   logic                x_issue_ready_i;
   logic [31:0]         x_issue_instr_o;
   logic [IdW-1:0]      x_issue_id_o;
   logic [3*XLEN-1:0]   x_issue_rs_o;
   logic [2:0]          x_issue_rs_valid_o;
   logic                x_issue_resp_accept_i;
   logic                x_issue_resp_writeback_i;
   logic [2:0]          x_issue_resp_register_read_i;
   logic                x_result_valid_i;
   logic                x_result_ready_o;
   logic [IdW-1:0]      x_result_id_i;
   logic [XLEN-1:0]     x_result_data_i;
   logic [4:0]          x_result_rd_i;
   logic                x_result_we_i;
   logic                wb_valid_o;
   logic [4:0]          wb_rd_o;
   logic [XLEN-1:0]     wb_data_o;
   logic                illegal_o, timeout_o, done_o, busy_o;

   cvxif_offload_ctrl #(.XLEN(XLEN), .IdW(IdW), .TimeoutCycles(64)) dut (
      .clk_i                        (clk_i),
      .rst_ni                       (rst_ni),
      .instr_valid_i                (instr_valid_i),
      .instr_ready_o                (instr_ready_o),
      .instr_i                      (instr_i),
      .rs1_i                        (rs1_i),
      .rs2_i                        (rs2_i),
      .rs3_i                        (rs3_i),
      .x_issue_valid_o              (x_issue_valid_o),
      .x_issue_ready_i              (x_issue_ready_i),
      .x_issue_instr_o              (x_issue_instr_o),
      .x_issue_id_o                 (x_issue_id_o),
      .x_issue_rs_o                 (x_issue_rs_o),
      .x_issue_rs_valid_o           (x_issue_rs_valid_o),
      .x_issue_resp_accept_i        (x_issue_resp_accept_i),
      .x_issue_resp_writeback_i     (x_issue_resp_writeback_i),
      .x_issue_resp_register_read_i (x_issue_resp_register_read_i),
      .x_result_valid_i             (x_result_valid_i),
      .x_result_ready_o             (x_result_ready_o),
      .x_result_id_i                (x_result_id_i),
      .x_result_data_i              (x_result_data_i),
      .x_result_rd_i                (x_result_rd_i),
      .x_result_we_i                (x_result_we_i),
      .wb_valid_o                   (wb_valid_o),
      .wb_rd_o                      (wb_rd_o),
      .wb_data_o                    (wb_data_o),
      .illegal_o                    (illegal_o),
      .timeout_o                    (timeout_o),
      .done_o                       (done_o),
      .busy_o                       (busy_o)
   );

   typedef struct {
      logic [2:0]  kind;
      logic [31:0] instr;
      logic [7:0]  tag;
      logic [95:0] data;
   } exp_t;

   exp_t       sb[$];
   int         total = 0;
   int         bad   = 0;
   logic       mon_en = 1'b0;
   logic [2:0] exp_id = 3'd0;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   function automatic string kname(input logic [2:0] k);
      case (k)
         K_ISS:   return "issue";
         K_WB:    return "writeback";
         K_DONE:  return "done";
         K_ILL:   return "illegal";
         K_TMO:   return "timeout";
         default: return "unknown";
      endcase
   endfunction

   function automatic void push(input logic [2:0] k, input logic [31:0] ins,
                                input logic [7:0] tag, input logic [95:0] data);
      exp_t e;
      e.kind  = k;
      e.instr = ins;
      e.tag   = tag;
      e.data  = data;
      sb.push_back(e);
   endfunction

   task automatic check_evt(input logic [2:0] k, input logic [31:0] ins,
                            input logic [7:0] tag, input logic [95:0] data);
      exp_t e;
      total++;
      if (sb.size() == 0) begin
         bad++;
         $display("FAIL unexpected_%s: got instr=%h tag=%h data=%h, expected no event",
                  kname(k), ins, tag, data);
      end else begin
         e = sb.pop_front();
         if (e.kind !== k || e.instr !== ins || e.tag !== tag || e.data !== data) begin
            bad++;
            $display("FAIL %s: got %s instr=%h tag=%h data=%h, expected %s instr=%h tag=%h data=%h",
                     kname(e.kind), kname(k), ins, tag, data, kname(e.kind), e.instr, e.tag, e.data);
         end
      end
   endtask

   // monitor: every DUT event in a cycle is matched against the scoreboard in a fixed order
   always @(negedge clk_i) begin
      if (mon_en) begin
         if (x_issue_valid_o && x_issue_ready_i)
            check_evt(K_ISS, x_issue_instr_o, {2'b00, x_issue_rs_valid_o, x_issue_id_o}, x_issue_rs_o);
         if (wb_valid_o)
            check_evt(K_WB, 32'd0, {3'b000, wb_rd_o}, {64'd0, wb_data_o});
         if (done_o)    check_evt(K_DONE, 32'd0, 8'd0, 96'd0);
         if (illegal_o) check_evt(K_ILL, 32'd0, 8'd0, 96'd0);
         if (timeout_o) check_evt(K_TMO, 32'd0, 8'd0, 96'd0);
         total++;
         if (!wb_valid_o && (wb_rd_o != 5'd0 || wb_data_o != '0)) begin
            bad++;
            $display("FAIL wb_idle_zero: got rd=%0d data=%h with wb_valid_o=0, expected 0",
                     wb_rd_o, wb_data_o);
         end
      end
   end

   task automatic check_reset_outputs(input string name);
      logic [13:0] got;
      got = {instr_ready_o, busy_o, x_issue_valid_o, |x_issue_instr_o, |x_issue_id_o,
             |x_issue_rs_o, |x_issue_rs_valid_o, x_result_ready_o, wb_valid_o, |wb_rd_o,
             |wb_data_o, illegal_o, timeout_o, done_o};
      total++;
      if (got !== 14'b10_0000_0000_0000) begin
         bad++;
         $display("FAIL %s: got outputs=%b, expected %b", name, got, 14'b10_0000_0000_0000);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!instr_ready_o && n < 200) begin
         @(posedge clk_i); #1;
         n++;
      end
      total++;
      if (!instr_ready_o) begin
         bad++;
         $display("FAIL wait_idle: got instr_ready_o=0 after %0d cycles, expected 1", n);
      end
   endtask

   task automatic do_issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] r3, input int dly, input logic acc,
                           input logic wbk, input logic [2:0] rr, input logic hs_res);
      wait_idle();
      push(K_ISS, ins, {2'b00, 3'b111, exp_id}, {r3, r2, r1});
      instr_valid_i = 1'b1;
      instr_i       = ins;
      rs1_i         = r1;
      rs2_i         = r2;
      rs3_i         = r3;
      @(posedge clk_i); #1;
      instr_valid_i = 1'b0;
      instr_i       = '0;
      rs1_i         = '0;
      rs2_i         = '0;
      rs3_i         = '0;
      repeat (dly) begin
         @(posedge clk_i); #1;
      end
      x_issue_ready_i              = 1'b1;
      x_issue_resp_accept_i        = acc;
      x_issue_resp_writeback_i     = wbk;
      x_issue_resp_register_read_i = rr;
      if (hs_res) begin
         x_result_valid_i = 1'b1;
         x_result_id_i    = exp_id;
         x_result_data_i  = 32'h0000_0BAD;
         x_result_rd_i    = 5'd9;
         x_result_we_i    = 1'b1;
      end
      @(posedge clk_i); #1;
      x_issue_ready_i              = 1'b0;
      x_issue_resp_accept_i        = 1'b0;
      x_issue_resp_writeback_i     = 1'b0;
      x_issue_resp_register_read_i = 3'b000;
      x_result_valid_i             = 1'b0;
      x_result_id_i                = '0;
      x_result_data_i              = '0;
      x_result_rd_i                = '0;
      x_result_we_i                = 1'b0;
      if (acc) exp_id = exp_id + 3'd1;
      if (!acc)      push(K_ILL, 32'd0, 8'd0, 96'd0);
      else if (!wbk) push(K_DONE, 32'd0, 8'd0, 96'd0);
   endtask

   task automatic send_result(input logic [2:0] id, input logic [31:0] data,
                              input logic [4:0] rd, input logic we);
      x_result_valid_i = 1'b1;
      x_result_id_i    = id;
      x_result_data_i  = data;
      x_result_rd_i    = rd;
      x_result_we_i    = we;
      @(posedge clk_i); #1;
      x_result_valid_i = 1'b0;
      x_result_id_i    = '0;
      x_result_data_i  = '0;
      x_result_rd_i    = '0;
      x_result_we_i    = 1'b0;
   endtask

   initial begin
      int n;
      rst_ni                       = 1'b0;
      instr_valid_i                = 1'b0;
      instr_i                      = '0;
      rs1_i                        = '0;
      rs2_i                        = '0;
      rs3_i                        = '0;
      x_issue_ready_i              = 1'b0;
      x_issue_resp_accept_i        = 1'b0;
      x_issue_resp_writeback_i     = 1'b0;
      x_issue_resp_register_read_i = 3'b000;
      x_result_valid_i             = 1'b0;
      x_result_id_i                = '0;
      x_result_data_i              = '0;
      x_result_rd_i                = '0;
      x_result_we_i                = 1'b0;

      repeat (3) @(posedge clk_i);
      #1;
      check_reset_outputs("reset_in_reset");
      rst_ni = 1'b1;
      mon_en = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         check_reset_outputs("reset_idle");
      end
      @(posedge clk_i); #1;

      // basic writeback, issue ready after 2 cycles
      do_issue(32'h0000_107B, 32'd5, 32'd7, 32'd0, 2, 1'b1, 1'b1, 3'b011, 1'b0);
      push(K_WB, 32'd0, 8'd2, 96'd12);
      push(K_DONE, 32'd0, 8'd0, 96'd0);
      send_result(3'd0, 32'd12, 5'd2, 1'b1);

      // accepted without writeback, ID 1
      do_issue(32'h0000_007B, 32'd1, 32'd2, 32'd3, 0, 1'b1, 1'b0, 3'b000, 1'b0);

      // rejected: ID 2 stays unconsumed
      do_issue(32'h0000_0033, 32'd9, 32'd8, 32'd7, 1, 1'b0, 1'b0, 3'b000, 1'b0);
      do_issue(32'h0000_207B, 32'd1, 32'd2, 32'd3, 1, 1'b1, 1'b0, 3'b000, 1'b0);

      // mismatched ID discarded, matching ID 3 written back
      do_issue(32'h0000_307B, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 0,
               1'b1, 1'b1, 3'b111, 1'b0);
      send_result(3'd2, 32'h0000_CAFE, 5'd4, 1'b1);
      repeat (2) begin
         @(posedge clk_i); #1;
      end
      push(K_WB, 32'd0, 8'd31, 96'hDEAD_BEEF);
      push(K_DONE, 32'd0, 8'd0, 96'd0);
      send_result(3'd3, 32'hDEAD_BEEF, 5'd31, 1'b1);

      // result with we=0, then with rd=0: done only
      do_issue(32'h0000_407B, 32'd4, 32'd4, 32'd4, 0, 1'b1, 1'b1, 3'b001, 1'b0);
      push(K_DONE, 32'd0, 8'd0, 96'd0);
      send_result(3'd4, 32'd99, 5'd5, 1'b0);
      do_issue(32'h0000_507B, 32'd5, 32'd5, 32'd5, 0, 1'b1, 1'b1, 3'b001, 1'b0);
      push(K_DONE, 32'd0, 8'd0, 96'd0);
      send_result(3'd5, 32'd77, 5'd0, 1'b1);

      // matched result in the last timeout cycle wins
      do_issue(32'h0000_607B, 32'd6, 32'd6, 32'd6, 0, 1'b1, 1'b1, 3'b011, 1'b0);
      repeat (63) begin
         @(posedge clk_i); #1;
      end
      push(K_WB, 32'd0, 8'd7, 96'h55);
      push(K_DONE, 32'd0, 8'd0, 96'd0);
      send_result(3'd6, 32'h55, 5'd7, 1'b1);

      // result during the issue handshake is ignored, so the transaction times out
      do_issue(32'h0000_707B, 32'd7, 32'd7, 32'd7, 0, 1'b1, 1'b1, 3'b011, 1'b1);
      push(K_TMO, 32'd0, 8'd0, 96'd0);
      n = 0;
      do begin
         @(negedge clk_i);
         n++;
      end while (!timeout_o && n < 200);
      total++;
      if (n != 65) begin
         bad++;
         $display("FAIL timeout_latency: got %0d wait cycles, expected 64", n - 1);
      end
      @(posedge clk_i); #1;
      do_issue(32'h0000_807B, 32'd8, 32'd8, 32'd8, 0, 1'b1, 1'b0, 3'b000, 1'b0);

      // reset during WAIT_RES: no pulses, ID back to 0
      do_issue(32'h0000_907B, 32'd9, 32'd9, 32'd9, 0, 1'b1, 1'b1, 3'b011, 1'b0);
      repeat (3) begin
         @(posedge clk_i); #1;
      end
      rst_ni = 1'b0;
      repeat (2) begin
         @(posedge clk_i); #1;
      end
      rst_ni = 1'b1;
      exp_id = 3'd0;
      check_reset_outputs("reset_mid_txn");

      // nine accepted transactions: IDs 0..7 then 0
      for (int i = 0; i < 9; i++) begin
         do_issue(32'h0000_007B | (32'(i) << 12), 32'(i), 32'(i + 1), 32'(i + 2), i % 2,
                  1'b1, 1'b0, 3'b000, 1'b0);
      end

      repeat (5) begin
         @(posedge clk_i); #1;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending events, expected 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
